// File: rtl/memory_writer.sv
// Capture RAM: stores a run of samples on write-strobe edges and
// offers an independent registered readback port.
module memory_writer #(
    parameter int DATA_SIZE   = 64,
    parameter int DATA_DEPTH  = 7514,
    parameter int ADDR_MODULE = 13
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_write,
    input  logic [DATA_SIZE-1:0]   i_data,
    input  logic [ADDR_MODULE-1:0] i_rd_addr,
    output logic [DATA_SIZE-1:0]   o_rd_data,
    output logic [ADDR_MODULE-1:0] o_wr_addr,
    output logic                   o_busy,
    output logic                   o_full,
    output logic                   o_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FULL
    } state_t;

    localparam logic [ADDR_MODULE-1:0] LAST_ADDR = ADDR_MODULE'(DATA_DEPTH - 1);
    localparam logic [ADDR_MODULE-1:0] FULL_ADDR = ADDR_MODULE'(DATA_DEPTH);

    logic [DATA_SIZE-1:0]   mem [DATA_DEPTH];
    state_t                 state;
    state_t                 state_next;
    logic                   last_start;
    logic                   last_write;
    logic                   start_edge;
    logic                   write_edge;
    logic                   wr_en;
    logic [ADDR_MODULE-1:0] addr_next;
    logic                   ovf_next;

    assign start_edge = i_start & ~last_start;
    assign write_edge = i_write & ~last_write;

    always_comb begin
        state_next = state;
        addr_next  = o_wr_addr;
        ovf_next   = o_overflow;
        wr_en      = 1'b0;
        // start wins over a coincident write edge, which is dropped
        if (start_edge) begin
            state_next = CAPTURE;
            addr_next  = '0;
            ovf_next   = 1'b0;
        end else if (write_edge) begin
            unique case (state)
                CAPTURE: begin
                    wr_en     = 1'b1;
                    addr_next = o_wr_addr + 1'b1;
                    if (o_wr_addr == LAST_ADDR) begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    ovf_next = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            o_wr_addr  <= '0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b0;
            o_full     <= 1'b0;
            last_start <= 1'b1;
            last_write <= 1'b1;
        end else begin
            state      <= state_next;
            o_wr_addr  <= addr_next;
            o_overflow <= ovf_next;
            o_busy     <= (state_next == CAPTURE);
            o_full     <= (state_next == FULL);
            last_start <= i_start;
            last_write <= i_write;
        end
    end

    // RAM contents survive reset; writes only ever target addresses below DATA_DEPTH
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[o_wr_addr] <= i_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_data <= '0;
        end else if (i_rd_addr < FULL_ADDR) begin
            o_rd_data <= mem[i_rd_addr];
        end else begin
            o_rd_data <= '0;
        end
    end

endmodule

// File: doc/memory_writer.md
Name: memory_writer

Overview:
- Capture-side counterpart of the block-RAM reader path. It records a run of DATA_SIZE-bit samples, for example filter outputs, into an internal inferred single-clock RAM.
- Address advances on each rising edge of a write strobe. The run ends full at DATA_DEPTH words.
- A second, independent registered read port lets the host or test logic dump the captured run afterwards.

Parameters:
- DATA_SIZE, 64: sample width in bits.
- DATA_DEPTH, 7514: number of RAM words; valid addresses are 0 .. DATA_DEPTH-1.
- ADDR_MODULE, 13: address/counter width; must satisfy 2**ADDR_MODULE >= DATA_DEPTH.

Ports:
- i_clock  in  1  single clock; all logic on posedge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  level input; its rising edge arms a new capture run.
- i_write  in  1  level strobe; its rising edge stores one sample.
- i_data  in  DATA_SIZE  sample written on a detected write edge.
- i_rd_addr  in  ADDR_MODULE  readback address.
- o_rd_data  out  DATA_SIZE  registered readback data.
- o_wr_addr  out  ADDR_MODULE  number of samples stored in the current run (next write address).
- o_busy  out  1  high in CAPTURE.
- o_full  out  1  high in FULL.
- o_overflow  out  1  sticky: a write edge arrived while FULL.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; o_wr_addr=0; o_busy=0; o_full=0; o_overflow=0; o_rd_data=0.
  - Edge-detect history registers last_start and last_write reset to 1. A level already high at reset release therefore produces no edge.
  - RAM contents are not cleared.
- Edge detect:
  - start_edge = i_start & ~last_start; write_edge = i_write & ~last_write.
  - History registers update every cycle in every state.
- State machine IDLE / CAPTURE / FULL:
  - start_edge in any state: o_wr_addr<=0, o_overflow<=0, next state CAPTURE. Start has priority; a simultaneous write_edge is dropped and not stored.
  - CAPTURE + write_edge: mem[o_wr_addr]<=i_data on that posedge, o_wr_addr<=o_wr_addr+1.
  - CAPTURE + write_edge with o_wr_addr==DATA_DEPTH-1: after storing, o_wr_addr<=DATA_DEPTH, next state FULL.
  - FULL + write_edge: nothing stored; o_overflow<=1. o_wr_addr holds DATA_DEPTH.
  - IDLE + write_edge: ignored, with no overflow flag.
- There is no wrap-around. The counter never exceeds DATA_DEPTH, and addresses >= DATA_DEPTH are never written.
- Outputs o_busy and o_full are registered state decodes, updated on the same posedge as the state change.
- Write latency:
  - A write edge seen in cycle N is committed at the end of cycle N.
  - o_wr_addr shows the increment from cycle N+1.
  - Readback of that address is valid from cycle N+2 (read issued at N+1).
- Readback port:
  - o_rd_data <= mem[i_rd_addr] each posedge, in all states; 1-cycle latency.
  - i_rd_addr >= DATA_DEPTH returns 0.
  - Read and write to the same address in the same cycle returns the old contents (read-first).
- Reset mid-run: returns to IDLE immediately. Already-written words stay readable; the counter restarts from 0 only on the next start_edge.

Test Plan:
1. Reset low, then release with i_start=1 and i_write=1 held -> no edges; state IDLE, o_wr_addr=0, all flags 0.
2. Start edge, then 4 write pulses with i_data=0x11..0x44 -> o_wr_addr=4, o_busy=1; reads of addresses 0..3 return 0x11, 0x22, 0x33, 0x44 one cycle after each address is applied.
3. Start, then DATA_DEPTH write pulses with i_data equal to the pulse index -> o_full=1 and o_wr_addr=7514 after the last pulse; read of address 7513 returns 7513. One more pulse -> o_overflow=1 and address 0 is unchanged.
4. In FULL, a start edge arriving in the same cycle as a write edge -> CAPTURE, o_wr_addr=0, o_overflow=0, no word written.
5. Write i_data=0xAA to address 2 while i_rd_addr=2 in the same cycle -> o_rd_data shows the previous value, then 0xAA on the next cycle. A read of address 8000 returns 0.
6. Assert reset after 10 writes -> outputs return to reset values immediately. After a new start, a read of address 5 still returns the pre-reset value until overwritten.
